blink_monitor: RTL and testbench
================================

# blink_monitor

Receive-side checker for the board's LED blink signal: takes an asynchronous square wave, synchronizes it to CLOCK_50, measures each half-period in clock cycles, and declares lock once consecutive half-periods match the expected value within tolerance. After lock, any out-of-tolerance or missing edge raises a sticky fault. It sits between a board input pin and the status LEDs, and provides self-check for the toggling-LED generator.

## Interface
- HALF_PERIOD, 50000000, expected cycles between consecutive edges (1 s at 50 MHz)
- TOL, 1000, allowed deviation, inclusive, in cycles
- LOCK_COUNT, 4, consecutive good measurements required for lock (>=1)
- CNT_W, 27, counter/measurement width; must hold HALF_PERIOD+TOL+1

- CLOCK_50  in  1  system clock; only clock
- KEY  in  1  reset, synchronous, active-high
- blink_in  in  1  asynchronous square-wave input
- edge_pulse  out  1  one-cycle pulse per detected edge (rise or fall)
- meas_valid  out  1  one-cycle pulse: half_period holds a new measurement
- half_period  out  CNT_W  last measured half-period, in cycles
- locked  out  1  high while state is LOCKED
- fault  out  1  sticky, high in FAULT

## Operation
- Two-flop synchronizer on blink_in, then an edge detector comparing the synchronized value with its previous value.
- Edge detection is suppressed for the first 3 cycles after KEY deasserts (priming), so the reset value cannot create a false edge.
- Cycle counter: loads 1 on an edge cycle; otherwise increments, saturating at HALF_PERIOD+TOL+1. On an edge, measured = counter value, which equals the cycle distance between the two edge_pulse assertions.
- Good measurement: HALF_PERIOD-TOL <= measured <= HALF_PERIOD+TOL. Bad: any other value.
- Timeout: counter reaches HALF_PERIOD+TOL+1 with no edge that cycle. An edge on that same cycle takes priority and is a bad measurement, not a timeout.
- good_run counter, 0..LOCK_COUNT.
- States:
  - IDLE: first edge -> MEASURE. Counter starts; no meas_valid; good_run=0.
  - MEASURE, on each edge (meas_valid=1):
    - good: good_run+1; when it reaches LOCK_COUNT -> LOCKED.
    - bad: good_run=0, stay.
  - MEASURE, timeout: -> IDLE, good_run=0.
  - LOCKED: good edge -> stay. Bad edge or timeout -> FAULT.
  - FAULT: stays until KEY. Measurement continues (meas_valid, half_period keep updating). locked=0.
- Reset value of every output is 0. Reset also clears the synchronizer, counter, good_run and priming, and sets the state to IDLE.

## Timing
- Input transition before clock edge k: s1 updates at k, s2 at k+1, and edge_pulse is high in the cycle after edge k+2. Latency is 3 cycles.
- meas_valid, half_period, locked and fault are registered and change in the same cycle as the corresponding edge_pulse.
- locked rises in the same cycle as the LOCK_COUNT-th consecutive good meas_valid; this is the (LOCK_COUNT+1)-th edge after IDLE.
- Timeout fault asserts in the cycle the counter reaches HALF_PERIOD+TOL+1, i.e. that many cycles after the last edge_pulse.
- KEY high at any clock edge: all outputs are 0 from the next cycle, regardless of state.
- Input toggling faster than 3 cycles per level is outside the specified range. Behaviour is then defined only as producing bad measurements.

## Structure
- Shared package blink_pkg holds:
  - state encoding localparams (IDLE, MEASURE, LOCKED, FAULT)
  - the default HALF_PERIOD constant (50000000), shared with the LED generator so both ends agree.
- Sub-module edge_sync: two-flop synchronizer, previous-value register, priming counter, edge output. The monitor FSM, counter and comparators stay in blink_monitor.

## Test plan
All scenarios use HALF_PERIOD=20, TOL=2, LOCK_COUNT=4, CNT_W=8.
- Reset with blink_in=1 held: all outputs 0 throughout reset; no edge_pulse in the 10 cycles after release.
- Square wave, half-period 20 cycles: first edge gives edge_pulse only. Next four edges give meas_valid with half_period=20. locked=1 in the same cycle as the 5th edge_pulse; fault=0.
- Tolerance boundaries:
  - half-periods of 18 and 22 lock normally.
  - half-period 23 gives meas_valid with half_period=23 and never locks.
  - half-period 17 never locks either.
- Locked, then input frozen: fault=1 and locked=0 exactly 23 cycles after the last edge_pulse.
- Locked, then one half-period of 17: fault=1 on that edge. Later 20-cycle periods keep fault=1, half_period=20 and locked=0.
- KEY pulsed while LOCKED or FAULT: outputs 0 on the next cycle. Re-lock requires 5 fresh edges.

Source files
------------

// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared state encoding and default blink half-period
package blink_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        MEASURE = ST_MEASURE,
        LOCKED  = ST_LOCKED,
        FAULT   = ST_FAULT
    } state_t;

    // Same constant feeds the LED generator so both ends agree on 1 s at 50 MHz.
    localparam int DEFAULT_HALF_PERIOD = 50000000;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with primed edge detector
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_det
);

    logic       s1;
    logic       s2;
    logic       prev;
    logic [1:0] prime;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            prime <= 2'd0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            if (prime != 2'd3) begin
                prime <= prime + 2'd1;
            end
        end
    end

    // Held off until the pipeline has refilled from the live input after reset.
    assign edge_det = (prime == 2'd3) && (s2 != prev);

endmodule

// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - half-period measurement, lock and sticky fault for the blink input
module blink_monitor
    import blink_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
    parameter int TOL         = 1000,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 27
) (
    input  logic             CLOCK_50,
    input  logic             KEY,
    input  logic             blink_in,
    output logic             edge_pulse,
    output logic             meas_valid,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             fault
);

    localparam int RUN_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(HALF_PERIOD - TOL);
    localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(HALF_PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD + TOL + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(LOCK_COUNT);

    logic             edge_now;
    state_t           state;
    logic [CNT_W-1:0] count;
    logic [RUN_W-1:0] good_run;
    logic             good;
    logic             timeout;

    edge_sync u_edge_sync (
        .clk      (CLOCK_50),
        .rst      (KEY),
        .din      (blink_in),
        .edge_det (edge_now)
    );

    assign good    = (count >= LO_LIM) && (count <= HI_LIM);
    // An edge on the saturation cycle is scored as a bad measurement instead.
    assign timeout = !edge_now && (count == CNT_MAX);

    always_ff @(posedge CLOCK_50) begin
        if (KEY) begin
            state       <= IDLE;
            count       <= '0;
            good_run    <= '0;
            edge_pulse  <= 1'b0;
            meas_valid  <= 1'b0;
            half_period <= '0;
            locked      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            edge_pulse <= edge_now;
            meas_valid <= 1'b0;

            if (edge_now) begin
                count <= CNT_W'(1);
            end else if (count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (edge_now) begin
                        state    <= MEASURE;
                        good_run <= '0;
                    end
                end
                MEASURE: begin
                    if (edge_now) begin
                        meas_valid  <= 1'b1;
                        half_period <= count;
                        if (!good) begin
                            good_run <= '0;
                        end else if (good_run == RUN_LAST) begin
                            good_run <= RUN_FULL;
                            state    <= LOCKED;
                            locked   <= 1'b1;
                        end else begin
                            good_run <= good_run + RUN_W'(1);
                        end
                    end else if (timeout) begin
                        state    <= IDLE;
                        good_run <= '0;
                    end
                end
                LOCKED: begin
                    if (edge_now) begin
                        meas_valid  <= 1'b1;
                        half_period <= count;
                    end
                    if ((edge_now && !good) || timeout) begin
                        state  <= FAULT;
                        locked <= 1'b0;
                        fault  <= 1'b1;
                    end
                end
                FAULT: begin
                    if (edge_now) begin
                        meas_valid  <= 1'b1;
                        half_period <= count;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - scoreboard bench for blink_monitor with a 20-cycle half-period
module tb_blink_monitor;

    localparam int TIMEOUT_EXP = 23;

    typedef struct packed {
        logic       mv;
        logic [7:0] hp;
        logic       lk;
        logic       ft;
    } exp_t;

    logic       clk = 1'b0;
    logic       key;
    logic       blink_in;
    logic       edge_pulse;
    logic       meas_valid;
    logic [7:0] half_period;
    logic       locked;
    logic       fault;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_pulse = 0;
    logic fault_q = 1'b0;
    logic chk_zero = 1'b0;
    logic watch = 1'b0;
    logic watch_done = 1'b0;
    logic end_chk = 1'b0;
    logic end_done = 1'b0;

    always #5 clk = ~clk;

    blink_monitor #(
        .HALF_PERIOD (20),
        .TOL         (2),
        .LOCK_COUNT  (4),
        .CNT_W       (8)
    ) dut (
        .CLOCK_50    (clk),
        .KEY         (key),
        .blink_in    (blink_in),
        .edge_pulse  (edge_pulse),
        .meas_valid  (meas_valid),
        .half_period (half_period),
        .locked      (locked),
        .fault       (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!watch) watch_done = 1'b0;
        if (chk_zero) check("reset_zero", {edge_pulse, meas_valid, half_period, locked, fault}, 0);
        if (edge_pulse) begin
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_edge", edge_pulse, 0);
            end else begin
                e = exp_q.pop_front();
                check("meas_valid", meas_valid, e.mv);
                if (e.mv) check("half_period", half_period, e.hp);
                check("locked", locked, e.lk);
                check("fault", fault, e.ft);
            end
        end else begin
            if (meas_valid) check("stray_meas_valid", meas_valid, 0);
            if (fault && !fault_q) begin
                if (watch && !watch_done) begin
                    check("timeout_cycles", cyc - last_pulse, TIMEOUT_EXP);
                    check("timeout_locked", locked, 0);
                    watch_done = 1'b1;
                end else begin
                    check("stray_fault", fault, 0);
                end
            end
        end
        if (watch && !watch_done && (cyc - last_pulse > 40)) begin
            check("timeout_missing", fault, 1);
            watch_done = 1'b1;
        end
        if (end_chk && !end_done) begin
            check("queue_drained", exp_q.size(), 0);
            end_done = 1'b1;
        end
        fault_q = fault;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edge_after(input int n, input bit mv, input int hp, input bit lk, input bit ft);
        exp_t e;
        wait_cyc(n);
        blink_in = ~blink_in;
        e.mv = mv;
        e.hp = hp[7:0];
        e.lk = lk;
        e.ft = ft;
        exp_q.push_back(e);
    endtask

    task automatic key_pulse();
        key = 1'b1;
        wait_cyc(1);
        chk_zero = 1'b1;
        wait_cyc(1);
        key = 1'b0;
        wait_cyc(4);
        chk_zero = 1'b0;
        wait_cyc(2);
    endtask

    task automatic lock_run(input int hp);
        edge_after(5, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) edge_after(hp, 1, hp, 0, 0);
        edge_after(hp, 1, hp, 1, 0);
    endtask

    initial begin
        key      = 1'b1;
        blink_in = 1'b1;
        wait_cyc(1);
        chk_zero = 1'b1;
        wait_cyc(3);
        key = 1'b0;
        wait_cyc(10);
        chk_zero = 1'b0;

        lock_run(20);
        edge_after(20, 1, 20, 1, 0);
        watch = 1'b1;
        wait_cyc(45);
        watch = 1'b0;
        key_pulse();

        lock_run(22);
        wait_cyc(6);
        key_pulse();

        lock_run(18);
        edge_after(17, 1, 17, 0, 1);
        edge_after(20, 1, 20, 0, 1);
        edge_after(20, 1, 20, 0, 1);
        wait_cyc(6);
        key_pulse();

        edge_after(5, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) edge_after(23, 1, 23, 0, 0);
        wait_cyc(6);
        key_pulse();

        edge_after(5, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) edge_after(17, 1, 17, 0, 0);
        wait_cyc(30);
        edge_after(0, 0, 0, 0, 0);
        wait_cyc(6);

        end_chk = 1'b1;
        wait_cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
